// File: rtl/b16_bus_arbiter_pkg.sv
// b16 bus arbiter shared definitions: state encoding, bus width and
// byte-strobe bit positions used by the arbiter and its interface.
package b16_bus_pkg;

  // Width of the b16 data/address bus
  localparam int B16_L = 16;

  // Bit positions inside the {hi, lo} byte write strobes
  localparam int WR_HI = 1;
  localparam int WR_LO = 0;

  // Arbiter states: CPU owns the bus, host access cycle, host completion cycle
  typedef enum logic [1:0] {
    ST_CPU = 2'b00,
    ST_ACC = 2'b01,
    ST_ACK = 2'b10
  } arb_state_t;

endpackage

// File: rtl/b16_bus_arbiter_if.sv
// Bundle of CPU, host and shared-memory signals around the b16 bus arbiter.
// The slave modport is the arbiter's view; master is the surrounding system
// (core, debugger, host master and memory decode).
interface b16_bus_arbiter_if
  import b16_bus_pkg::*;
#(
  parameter int l = B16_L
);

  // core / debugger side
  logic         run_in;
  logic         cpu_run;
  logic [l-1:0] cpu_addr;
  logic         cpu_rd;
  logic [1:0]   cpu_wr;
  logic [l-1:0] cpu_wdata;
  logic [l-1:0] cpu_rdata;

  // external host master side
  logic         host_req;
  logic         host_we;
  logic [1:0]   host_be;
  logic [l-1:0] host_addr;
  logic [l-1:0] host_wdata;
  logic         host_ack;
  logic [l-1:0] host_rdata;

  // shared memory port
  logic [l-1:0] mem_addr;
  logic         mem_rd;
  logic [1:0]   mem_wr;
  logic [l-1:0] mem_wdata;
  logic [l-1:0] mem_rdata;

  modport slave (
    input  run_in, cpu_addr, cpu_rd, cpu_wr, cpu_wdata,
    input  host_req, host_we, host_be, host_addr, host_wdata,
    input  mem_rdata,
    output cpu_run, cpu_rdata, host_ack, host_rdata,
    output mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport master (
    output run_in, cpu_addr, cpu_rd, cpu_wr, cpu_wdata,
    output host_req, host_we, host_be, host_addr, host_wdata,
    output mem_rdata,
    input  cpu_run, cpu_rdata, host_ack, host_rdata,
    input  mem_addr, mem_rd, mem_wr, mem_wdata
  );

endinterface

// File: rtl/b16_bus_arbiter.sv
// b16 bus arbiter: shares the core's memory bus with one external host.
// The CPU owns the bus by default; a host request stalls the core through
// cpu_run and runs a two-cycle ACC/ACK access on the shared port.
// Optional feature macro: B16_ARB_FAIR_EN -- limits host bursts to MAX_BURST
// accesses, then hands the CPU at least one cycle back.
module b16_bus_arbiter
  import b16_bus_pkg::*;
#(
  parameter int l         = B16_L,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              nreset,
  b16_bus_arbiter_if.slave  bus
);

  // Burst limit is held in a 4-bit counter, so it must fit 1..15
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_max_burst_range
    $error("b16_bus_arbiter: MAX_BURST out of range 1..15");
  end

  arb_state_t   state_reg, state_next;
  logic         host_ack_reg;
  logic [l-1:0] host_rdata_reg;
  logic [1:0]   host_wr;

`ifdef B16_ARB_FAIR_EN
  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);
  logic [3:0] burst_cnt_reg, burst_cnt_next;
  logic       owed_reg, owed_next;
`endif

  // Host byte strobes only reach memory on writes
  genvar gi;
  for (gi = WR_LO; gi <= WR_HI; gi++) begin : g_host_wr
    assign host_wr[gi] = bus.host_we & bus.host_be[gi];
  end

  // Next-state logic; ACK never re-samples host_req for the finished access
  always_comb begin
    state_next = state_reg;
`ifdef B16_ARB_FAIR_EN
    burst_cnt_next = burst_cnt_reg;
    owed_next      = owed_reg;
`endif
    case (state_reg)
      ST_CPU: begin
`ifdef B16_ARB_FAIR_EN
        owed_next = 1'b0;
        if (bus.host_req && !owed_reg) state_next = ST_ACC;
`else
        if (bus.host_req) state_next = ST_ACC;
`endif
      end
      ST_ACC: begin
        state_next = ST_ACK;
`ifdef B16_ARB_FAIR_EN
        burst_cnt_next = burst_cnt_reg + 4'd1;
`endif
      end
      ST_ACK: begin
`ifdef B16_ARB_FAIR_EN
        if (bus.host_req && (burst_cnt_reg < BURST_LIMIT)) begin
          state_next = ST_ACC;
        end else begin
          state_next = ST_CPU;
          // a pending request here means the burst limit forced the exit
          owed_next  = bus.host_req;
        end
`else
        state_next = bus.host_req ? ST_ACC : ST_CPU;
`endif
      end
      default: state_next = ST_CPU;
    endcase
`ifdef B16_ARB_FAIR_EN
    if (state_next == ST_CPU) burst_cnt_next = '0;
`endif
  end

  // State, flags and registered host outputs
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_reg      <= ST_CPU;
      host_ack_reg   <= 1'b0;
      host_rdata_reg <= '0;
`ifdef B16_ARB_FAIR_EN
      burst_cnt_reg  <= '0;
      owed_reg       <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      host_ack_reg <= (state_reg == ST_ACC);
      if ((state_reg == ST_ACC) && !bus.host_we) host_rdata_reg <= bus.mem_rdata;
`ifdef B16_ARB_FAIR_EN
      burst_cnt_reg <= burst_cnt_next;
      owed_reg      <= owed_next;
`endif
    end
  end

  // Shared-port muxes and core stall, driven from the state register only
  always_comb begin
    bus.cpu_run   = bus.run_in;
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_rd    = bus.cpu_rd;
    bus.mem_wr    = bus.cpu_wr;
    bus.mem_wdata = bus.cpu_wdata;
    case (state_reg)
      ST_ACC: begin
        bus.cpu_run   = 1'b0;
        bus.mem_addr  = bus.host_addr;
        bus.mem_rd    = !bus.host_we;
        bus.mem_wr    = host_wr;
        bus.mem_wdata = bus.host_wdata;
      end
      ST_ACK: begin
        bus.cpu_run = 1'b0;
        bus.mem_rd  = 1'b0;
        bus.mem_wr  = 2'b00;
      end
      default: ;
    endcase
  end

  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.host_ack   = host_ack_reg;
  assign bus.host_rdata = host_rdata_reg;

endmodule

// File: tb/tb_b16_bus_arbiter.sv
// Directed bench for b16_bus_arbiter: passthrough, host read/write,
// halted core, continuous host bursts and reset in the middle of a burst.
module tb_b16_bus_arbiter;
  import b16_bus_pkg::*;

  logic clk = 1'b0;
  logic nreset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  b16_bus_arbiter_if #(.l(16)) bus ();

  b16_bus_arbiter #(.l(16), .MAX_BURST(4)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected (cpu_run, host_ack) in cycle i (1-based) of a held host request
  task automatic burst_exp(input int i, output logic run_e, output logic ack_e);
    int k;
`ifdef B16_ARB_FAIR_EN
    // 4 ACC/ACK pairs, then CPU with owed set, then CPU re-arbitrating
    k = (i - 1) % 10;
    run_e = (k >= 8);
    ack_e = (k < 8) && (k % 2 == 1);
`else
    k = i;
    run_e = 1'b0;
    ack_e = (k % 2 == 0);
`endif
  endtask

  initial begin
    logic run_e, ack_e;

    // reset with idle inputs
    nreset         = 1'b0;
    bus.run_in     = 1'b1;
    bus.cpu_addr   = '0;
    bus.cpu_rd     = 1'b0;
    bus.cpu_wr     = 2'b00;
    bus.cpu_wdata  = '0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_be    = 2'b00;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.mem_rdata  = '0;
    tick();
    tick();
    chk("rst_ack", bus.host_ack, 0);
    chk("rst_rdata", bus.host_rdata, 0);
    chk("rst_run", bus.cpu_run, 1);
    nreset = 1'b1;

    // idle passthrough
    bus.cpu_addr  = 16'h3FFE;
    bus.cpu_rd    = 1'b1;
    bus.cpu_wr    = 2'b10;
    bus.cpu_wdata = 16'h5A5A;
    bus.mem_rdata = 16'h1234;
    #1;
    chk("pass_rdata", bus.cpu_rdata, 16'h1234);
    chk("pass_addr", bus.mem_addr, 16'h3FFE);
    chk("pass_rd", bus.mem_rd, 1);
    chk("pass_wr", bus.mem_wr, 2'b10);
    chk("pass_wdata", bus.mem_wdata, 16'h5A5A);
    chk("pass_run", bus.cpu_run, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("pass_noack%0d", i), bus.host_ack, 0);
    end
    bus.cpu_rd = 1'b0;
    bus.cpu_wr = 2'b00;

    // host read at 0x0100
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 16'h0100;
    tick();                         // ACC
    bus.mem_rdata = 16'hBEEF;
    #1;
    chk("rd_acc_run", bus.cpu_run, 0);
    chk("rd_acc_addr", bus.mem_addr, 16'h0100);
    chk("rd_acc_rd", bus.mem_rd, 1);
    chk("rd_acc_wr", bus.mem_wr, 2'b00);
    chk("rd_acc_ack", bus.host_ack, 0);
    tick();                         // ACK
    bus.mem_rdata = 16'h0000;
    #1;
    chk("rd_ack_ack", bus.host_ack, 1);
    chk("rd_ack_rdata", bus.host_rdata, 16'hBEEF);
    chk("rd_ack_run", bus.cpu_run, 0);
    chk("rd_ack_memrd", bus.mem_rd, 0);
    bus.host_req = 1'b0;
    tick();                         // CPU
    chk("rd_done_ack", bus.host_ack, 0);
    chk("rd_done_run", bus.cpu_run, 1);

    // host low-byte write at 0x0200
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_be    = 2'b01;
    bus.host_addr  = 16'h0200;
    bus.host_wdata = 16'h00AA;
    tick();                         // ACC
    chk("wr_acc_wr", bus.mem_wr, 2'b01);
    chk("wr_acc_rd", bus.mem_rd, 0);
    chk("wr_acc_addr", bus.mem_addr, 16'h0200);
    chk("wr_acc_wdata", bus.mem_wdata, 16'h00AA);
    chk("wr_acc_run", bus.cpu_run, 0);
    tick();                         // ACK
    chk("wr_ack_wr", bus.mem_wr, 2'b00);
    chk("wr_ack_ack", bus.host_ack, 1);
    chk("wr_ack_rdata_hold", bus.host_rdata, 16'hBEEF);
    bus.host_req = 1'b0;
    bus.host_we  = 1'b0;
    tick();

    // request withdrawn during ACC still completes
    bus.host_req  = 1'b1;
    bus.host_addr = 16'h0300;
    tick();                         // ACC
    bus.mem_rdata = 16'h1111;
    bus.host_req  = 1'b0;
    tick();                         // ACK
    chk("drop_ack", bus.host_ack, 1);
    chk("drop_rdata", bus.host_rdata, 16'h1111);
    tick();
    chk("drop_done_ack", bus.host_ack, 0);

    // halted core: host still served, cpu_run low everywhere
    bus.run_in = 1'b0;
    #1;
    chk("halt_cpu_run", bus.cpu_run, 0);
    bus.host_req  = 1'b1;
    bus.host_addr = 16'h0400;
    bus.mem_rdata = 16'h2222;
    tick();
    chk("halt_acc_run", bus.cpu_run, 0);
    tick();
    chk("halt_ack_run", bus.cpu_run, 0);
    chk("halt_ack", bus.host_ack, 1);
    chk("halt_rdata", bus.host_rdata, 16'h2222);
    bus.host_req = 1'b0;
    tick();
    chk("halt_done_run", bus.cpu_run, 0);
    bus.run_in = 1'b1;

    // continuous host request
    bus.host_req  = 1'b1;
    bus.mem_rdata = 16'h7777;
    for (int i = 1; i <= 20; i++) begin
      tick();
      burst_exp(i, run_e, ack_e);
      chk($sformatf("burst%0d_run", i), bus.cpu_run, run_e);
      chk($sformatf("burst%0d_ack", i), bus.host_ack, ack_e);
    end
    bus.host_req = 1'b0;
    tick();
    tick();

    // reset during an ACC cycle of a burst
    bus.host_req  = 1'b1;
    bus.mem_rdata = 16'h4444;
    tick();                         // ACC
    tick();                         // ACK
    chk("mid_ack", bus.host_ack, 1);
    chk("mid_rdata", bus.host_rdata, 16'h4444);
    tick();                         // second ACC
    chk("mid_acc_run", bus.cpu_run, 0);
    nreset = 1'b0;
    tick();                         // CPU after reset
    chk("mrst_ack", bus.host_ack, 0);
    chk("mrst_rdata", bus.host_rdata, 0);
    chk("mrst_run", bus.cpu_run, 1);
    chk("mrst_memrd", bus.mem_rd, 0);
    nreset = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      burst_exp(i, run_e, ack_e);
      chk($sformatf("post_rst%0d_run", i), bus.cpu_run, run_e);
      chk($sformatf("post_rst%0d_ack", i), bus.host_ack, ack_e);
    end
    bus.host_req = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
